// File: rtl/autobox_pkg.sv
// autobox_pkg -- shared constants for the automatic gearbox controller.
// Holds the gear codes (also used as FSM state encodings), lever encodings,
// the speed thresholds and small helpers for the gear-selection rules.
package autobox_pkg;

  // Gear codes double as FSM state encodings. Code 7 is never produced.
  localparam logic [2:0] GEAR_P  = 3'd0;
  localparam logic [2:0] GEAR_R  = 3'd1;
  localparam logic [2:0] GEAR_N  = 3'd2;
  localparam logic [2:0] GEAR_D1 = 3'd3;
  localparam logic [2:0] GEAR_D2 = 3'd4;
  localparam logic [2:0] GEAR_D3 = 3'd5;
  localparam logic [2:0] GEAR_D4 = 3'd6;

  localparam logic [1:0] LEVER_P = 2'b00;
  localparam logic [1:0] LEVER_R = 2'b01;
  localparam logic [1:0] LEVER_N = 2'b10;
  localparam logic [1:0] LEVER_D = 2'b11;

  // Upshift thresholds (speed >= value).
  localparam logic [6:0] UP_D1_D2 = 7'd20;
  localparam logic [6:0] UP_D2_D3 = 7'd40;
  localparam logic [6:0] UP_D3_D4 = 7'd60;
  // Downshift thresholds (speed < value); lower than the upshift ones for hysteresis.
  localparam logic [6:0] DN_D4_D3 = 7'd50;
  localparam logic [6:0] DN_D3_D2 = 7'd30;
  localparam logic [6:0] DN_D2_D1 = 7'd12;

  localparam logic [6:0] R_SPEED_MAX    = 7'd5;
  localparam logic [6:0] KICK_SPEED_MAX = 7'd70;

  // Drive gear chosen when D is engaged from P/R/N.
  function automatic logic [2:0] entry_gear(input logic [6:0] speed);
    if (speed < UP_D1_D2)      return GEAR_D1;
    else if (speed < UP_D2_D3) return GEAR_D2;
    else if (speed < UP_D3_D4) return GEAR_D3;
    else                       return GEAR_D4;
  endfunction

  function automatic logic upshift_due(input logic [2:0] gear, input logic [6:0] speed);
    case (gear)
      GEAR_D1: return speed >= UP_D1_D2;
      GEAR_D2: return speed >= UP_D2_D3;
      GEAR_D3: return speed >= UP_D3_D4;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic downshift_due(input logic [2:0] gear, input logic [6:0] speed);
    case (gear)
      GEAR_D4: return speed < DN_D4_D3;
      GEAR_D3: return speed < DN_D3_D2;
      GEAR_D2: return speed < DN_D2_D1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_dwell_timer.sv
// shift_dwell_timer -- 4-bit hold-off counter between automatic shifts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : state is changing this cycle; reload LOAD_VAL
//   zero       : counter has expired, an automatic shift may happen
module shift_dwell_timer #(
  parameter int unsigned LOAD_VAL = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic zero
);

  localparam logic [3:0] LOAD_CNT = 4'(LOAD_VAL);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                count_d = LOAD_CNT;
    else if (count_q != 4'd0) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 4'd0;
    else        count_q <= count_d;
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/tt_um_fms_moisespabloc.sv
// tt_um_fms_moisespabloc -- automatic gearbox controller (Tiny Tapeout top).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (returns to PARK)
//   ena        : unused
//   ui_in      : [6:0] speed km/h, [7] kickdown pedal
//   uio_in     : [1:0] lever (P/R/N/D), [2] brake
//   uo_out     : [2:0] gear, [3] shift pulse, [4] reverse lamp, [5] park lock,
//                [6] fault, [7] kickdown active
//   uio_out    : [7:4] one-hot D1..D4, [3:0] zero
//   uio_oe     : constant 8'hF0
// Optional feature: define AUTOBOX_KICKDOWN_EN to enable kickdown downshifts.
module tt_um_fms_moisespabloc
  import autobox_pkg::*;
#(
  parameter int unsigned SHIFT_DWELL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [6:0] speed;
  logic [1:0] lever;
  logic       brake;
  assign speed = ui_in[6:0];
  assign lever = uio_in[1:0];
  assign brake = uio_in[2];

  logic [2:0] state_q, state_d;
  logic       fault_q, fault_d;
  logic       shift_q, shift_d;
  logic       kick_q, kick_d;
  logic       dwell_zero;
  logic       kick_req;
  logic       in_drive;

  assign in_drive = (state_q >= GEAR_D1);

`ifdef AUTOBOX_KICKDOWN_EN
  assign kick_req = ui_in[7] && (state_q >= GEAR_D2) && (speed < KICK_SPEED_MAX);
`else
  assign kick_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    kick_d  = 1'b0;
    // Leaving PARK for anything but P needs the brake pedal.
    if (state_q == GEAR_P && lever != LEVER_P && !brake) begin
      fault_d = 1'b1;
    end else begin
      case (lever)
        LEVER_P: begin
          if (speed == 7'd0) state_d = GEAR_P;
          else begin
            state_d = GEAR_N;
            fault_d = 1'b1;
          end
        end
        LEVER_R: begin
          if (speed <= R_SPEED_MAX) state_d = GEAR_R;
          else begin
            state_d = GEAR_N;
            fault_d = 1'b1;
          end
        end
        LEVER_N: state_d = GEAR_N;
        default: begin
          if (!in_drive) begin
            state_d = entry_gear(speed);
          end else if (dwell_zero) begin
            // Kickdown beats upshift; up/down thresholds never overlap.
            if (kick_req) begin
              state_d = state_q - 3'd1;
              kick_d  = 1'b1;
            end else if (upshift_due(state_q, speed)) begin
              state_d = state_q + 3'd1;
            end else if (downshift_due(state_q, speed)) begin
              state_d = state_q - 3'd1;
            end
          end
        end
      endcase
    end
    shift_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GEAR_P;
      fault_q <= 1'b0;
      shift_q <= 1'b0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      shift_q <= shift_d;
      kick_q  <= kick_d;
    end
  end

  shift_dwell_timer #(
    .LOAD_VAL(SHIFT_DWELL - 1)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .load (shift_d),
    .zero (dwell_zero)
  );

  logic [3:0] drive_onehot;
  assign drive_onehot = in_drive ? (4'b0001 << (state_q - GEAR_D1)) : 4'b0000;

  logic kick_out;
`ifdef AUTOBOX_KICKDOWN_EN
  assign kick_out = kick_q;
`else
  assign kick_out = 1'b0;
`endif

  assign uo_out  = {kick_out, fault_q, (state_q == GEAR_P), (state_q == GEAR_R),
                    shift_q, state_q};
  assign uio_out = {drive_onehot, 4'b0000};
  assign uio_oe  = 8'hF0;

  // Inputs with no function in this design.
`ifdef AUTOBOX_KICKDOWN_EN
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:3], kick_q};
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:3], ui_in[7], kick_q};
`endif

endmodule

// File: tb/tb_tt_um_fms_moisespabloc.sv
module tb_tt_um_fms_moisespabloc;

  localparam int SHIFT_DWELL = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_fms_moisespabloc #(.SHIFT_DWELL(SHIFT_DWELL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Gear is an integer 0..6; dwell is tracked as "cycles since the last gear
  // change" and an automatic shift is allowed once that reaches SHIFT_DWELL.
  int m_gear  = 0;
  int m_since = SHIFT_DWELL;
  bit m_fault = 0;
  bit m_shift = 0;
  bit m_kd    = 0;
  int up_at [3] = '{20, 40, 60};   // from D1, D2, D3
  int dn_blw[3] = '{12, 30, 50};   // from D2, D3, D4

  always @(posedge clk or negedge rst_n) begin
    int spd, lev, nxt;
    bit brk, kick, refused, kdc;
    if (!rst_n) begin
      m_gear = 0; m_since = SHIFT_DWELL; m_fault = 0; m_shift = 0; m_kd = 0;
    end else begin
      spd = int'(ui_in[6:0]); lev = int'(uio_in[1:0]); brk = uio_in[2]; kick = ui_in[7];
      nxt = m_gear; refused = 0; kdc = 0;
      if (m_gear == 0 && lev != 0 && !brk) refused = 1;
      else if (lev == 0) begin
        if (spd == 0) nxt = 0; else begin nxt = 2; refused = 1; end
      end else if (lev == 1) begin
        if (spd <= 5) nxt = 1; else begin nxt = 2; refused = 1; end
      end else if (lev == 2) nxt = 2;
      else if (m_gear < 3) begin
        nxt = 3 + int'(spd >= 20) + int'(spd >= 40) + int'(spd >= 60);
      end else if (m_since >= SHIFT_DWELL) begin
`ifdef AUTOBOX_KICKDOWN_EN
        if (kick && m_gear >= 4 && spd < 70) begin nxt = m_gear - 1; kdc = 1; end
        else
`endif
        if (m_gear < 6 && spd >= up_at[m_gear-3]) nxt = m_gear + 1;
        else if (m_gear > 3 && spd < dn_blw[m_gear-4]) nxt = m_gear - 1;
      end
      m_shift = (nxt != m_gear);
      m_since = m_shift ? 1 : m_since + 1;
      m_gear  = nxt;
      m_fault = refused;
      m_kd    = kdc;
    end
  end

  function automatic logic [7:0] exp_uo();
    logic [2:0] g;
    g = 3'(m_gear);
    return {m_kd, m_fault, (m_gear == 0), (m_gear == 1), m_shift, g};
  endfunction

  function automatic logic [7:0] exp_uio();
    logic [7:0] one;
    one = 8'h10;
    return (m_gear >= 3) ? (one << (m_gear - 3)) : 8'h00;
  endfunction

  // Compare process: outputs are registered, check every cycle mid-period.
  always @(negedge clk) begin
    check("model_uo_out", uo_out, exp_uo());
    check("model_uio_out", uio_out, exp_uio());
    check("uio_oe", uio_oe, 8'hF0);
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input int lev, input bit brk, input int spd, input bit kick);
    uio_in = {5'b0, brk, 2'(lev)};
    ui_in  = {kick, 7'(spd)};
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    $display("t=%0t lever=%0d brake=%0b speed=%0d kick=%0b -> uo_out=%02h uio_out=%02h",
             $time, uio_in[1:0], uio_in[2], ui_in[6:0], ui_in[7], uo_out, uio_out);
  endtask

  initial begin
    ena = 1'b1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    tick(2);
    check("reset_uo", uo_out, 8'h20);
    check("reset_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    tick(1);
    check("park_idle", uo_out, 8'h20);

    // D without brake refused, then with brake -> D1
    drive(3, 0, 0, 0); tick(1); check("park_no_brake", uo_out, 8'h60);
    drive(3, 1, 0, 0); tick(1); check("enter_d1", uo_out, 8'h0B);
    check("enter_d1_uio", uio_out, 8'h10);
    tick(1); check("d1_pulse_gone", uo_out, 8'h03);

    // Ramp 0..65
    for (int s = 0; s <= 65; s++) begin
      drive(3, 0, s, 0); tick(1);
      if (s == 20) check("ramp_d2", uo_out, 8'h0C);
      if (s == 40) check("ramp_d3", uo_out, 8'h0D);
      if (s == 60) check("ramp_d4", uo_out, 8'h0E);
    end
    check("ramp_end_uio", uio_out, 8'h80);

    // Hysteresis
    drive(3, 0, 55, 0); tick(10); check("hold_d4_55", uo_out, 8'h06);
    drive(3, 0, 45, 0); tick(1);  check("down_d3_45", uo_out, 8'h0D);
    drive(3, 0, 30, 0); tick(3);  check("hold_d3_30", uo_out, 8'h05);

    // Lever R at speed refused, then P at standstill
    drive(1, 0, 30, 0); tick(1); check("r_at_speed", uo_out, 8'h4A);
    drive(0, 0, 0, 0);  tick(1); check("back_to_park", uo_out, 8'h28);
    tick(1); check("park_steady", uo_out, 8'h20);

    // Dwell spacing: jump speed to 65 from D1
    drive(3, 1, 0, 0); tick(1); check("d1_again", uo_out, 8'h0B);
    tick(9);
    drive(3, 0, 65, 0); tick(1); check("jump_d2", uo_out, 8'h0C);
    tick(7); check("dwell_hold_d2", uo_out, 8'h04);
    tick(1); check("dwell_d3", uo_out, 8'h0D);
    tick(7); check("dwell_hold_d3", uo_out, 8'h05);
    tick(1); check("dwell_d4", uo_out, 8'h0E);

    // Reverse speed boundary 5/6
    drive(1, 0, 3, 0); tick(1); check("rev_3", uo_out, 8'h19);
    drive(1, 0, 6, 0); tick(1); check("rev_6_refused", uo_out, 8'h4A);
    drive(1, 0, 5, 0); tick(1); check("rev_5", uo_out, 8'h19);
    drive(2, 0, 5, 0); tick(1); check("neutral", uo_out, 8'h0A);
    drive(0, 0, 5, 0); tick(1); check("park_moving", uo_out, 8'h42);
    drive(0, 0, 0, 0); tick(1); check("park_stop", uo_out, 8'h28);
    drive(1, 0, 0, 0); tick(1); check("park_r_no_brake", uo_out, 8'h60);
    drive(1, 1, 0, 0); tick(1); check("park_r_brake", uo_out, 8'h19);
    drive(3, 1, 25, 0); tick(1); check("d_entry_25", uo_out, 8'h0C);
    check("d_entry_25_uio", uio_out, 8'h20);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1 check("async_reset_uo", uo_out, 8'h20);
    check("async_reset_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1); check("after_reset_d2", uo_out, 8'h0C);

`ifdef AUTOBOX_KICKDOWN_EN
    drive(3, 0, 65, 0); tick(30); check("kd_setup_d4", uo_out, 8'h06);
    drive(3, 0, 65, 1); tick(1);  check("kickdown_d3", uo_out, 8'h8D);
    drive(3, 0, 65, 0); tick(20); check("kd_back_d4", uo_out, 8'h06);
    drive(3, 0, 75, 1); tick(1);  check("kd_too_fast", uo_out, 8'h06);
    drive(3, 0, 75, 0); tick(1);
`else
    drive(3, 0, 65, 0); tick(30); check("nokd_setup_d4", uo_out, 8'h06);
    drive(3, 0, 65, 1); tick(1);  check("kick_ignored", uo_out, 8'h06);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
